alarm_time_setter: RTL
======================

Name: alarm_time_setter

Overview:
- Writer side of the 16-bit alarm-time register that the alarm checker reads.
- The user enters edit mode with a switch, then uses debounced push buttons to step the hours and minutes fields in packed BCD (HH:MM).
- A commit button writes the edited value to the alarm register and pulses a done strobe.
- The block sits between the board I/O (switches, push buttons) and the alarm input of the alarm/minigame service.

Parameters:
- REPEAT_DELAY, 50_000_000: cycles an up/down button must be held before auto-repeat starts.
- REPEAT_PERIOD, 10_000_000: cycles between auto-repeat steps once repeating.
- ALARM_INIT, 16'h0700: reset value of alarm (07:00 in BCD).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- resetn  input  1  asynchronous, active-high reset. The name is kept for port-map compatibility; the polarity is high.
- SPDT_set  input  1  edit-mode switch; level 1 requests edit mode.
- push_l  input  1  debounced level; select the hours field.
- push_r  input  1  debounced level; select the minutes field.
- push_u  input  1  debounced level; increment the selected field.
- push_d  input  1  debounced level; decrement the selected field.
- push_c  input  1  debounced level; commit the edited value.
- alarm  output  16  committed alarm time {H10,H1,M10,M1}, BCD.
- disp_time  output  16  value to display: the working copy in edit mode, otherwise alarm.
- field_sel  output  1  0 = hours, 1 = minutes; valid in edit mode only.
- editing  output  1  1 while in the EDIT state.
- set_done  output  1  one-cycle pulse on commit.

Behaviour:
- Reset (async, high) sets:
  - alarm = ALARM_INIT, working copy = ALARM_INIT;
  - state = IDLE, field_sel = 0, editing = 0, set_done = 0;
  - repeat counter = 0;
  - all button edge-history registers = 0.
- Edge detection: each push_* input is registered once. An event is a 0->1 transition of the registered value, so response latency is 1 cycle after the registered input rises.
- IDLE:
  - editing = 0; disp_time = alarm.
  - Entry to EDIT is on a rising edge of SPDT_set (registered). On entry: working = alarm, field_sel = 0.
  - Button events in IDLE are ignored.
- EDIT:
  - editing = 1; disp_time = working.
  - If SPDT_set = 0, go to IDLE (cancel): discard working, leave alarm unchanged, no set_done. Cancel has priority over all buttons in the same cycle.
  - Otherwise, for a single event in one cycle, the priority is c > (u xor d) > l/r:
    - c: go to COMMIT.
    - u alone: increment the selected field.
    - d alone: decrement the selected field.
    - u and d together: no change.
    - l: field_sel = 0. r: field_sel = 1. l and r together: no change.
- COMMIT (1 cycle):
  - alarm = working; set_done = 1 for exactly this cycle.
  - Next state is EDIT if SPDT_set = 1 (working is kept), otherwise IDLE.
- Field arithmetic (BCD, always valid):
  - Hours increment 00..23; 23 -> 00 on increment, 00 -> 23 on decrement.
  - Minutes increment 00..59; 59 -> 00 on increment, 00 -> 59 on decrement.
  - Units digit carries into the tens digit: 09 -> 10 and 19 -> 20 on increment; 10 -> 09 on decrement.
  - Stepping one field never changes the other.
- Auto-repeat:
  - Applies when exactly one of push_u / push_d is held in EDIT.
  - Repeat counter starts at the initial press edge.
  - After REPEAT_DELAY cycles of continuous hold, one extra step occurs, then one step every REPEAT_PERIOD cycles.
  - Release, pressing the other direction, a field change, commit, or cancel clears the counter.
  - The counter is sized with clog2 of max(REPEAT_DELAY, REPEAT_PERIOD) + 1.
- alarm changes only in COMMIT or on reset.
- Mid-edit reset: the block returns to IDLE with alarm = ALARM_INIT.

Test Plan:
All scenarios use REPEAT_DELAY = 4 and REPEAT_PERIOD = 2.
1. Reset, then idle 10 cycles -> alarm = disp_time = 16'h0700, editing = 0, set_done = 0.
2. SPDT_set = 1, three push_u taps, push_c -> disp_time steps 08, 09, 10 hours; alarm = 16'h1000; set_done high for exactly 1 cycle; editing stays 1.
3. Wrap: enter EDIT with alarm 16'h2359; push_u, push_r, push_u, push_c -> alarm = 16'h0000. Then push_d on minutes, commit -> alarm = 16'h0059.
4. Cancel: enter EDIT, push_u twice, drop SPDT_set -> editing = 0, alarm unchanged, no set_done. Re-enter EDIT -> working reloaded from alarm.
5. Auto-repeat: hold push_u 12 cycles on minutes from 16'h0700 -> steps at press, press + 4, + 6, + 8, + 10 cycles; disp_time = 16'h0705. Press push_u and push_d together -> no change.
6. Priority/reset: push_c and push_u in the same cycle -> alarm gets the pre-increment working value. Assert resetn high mid-EDIT -> outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/alarm_time_setter.sv
// Alarm-time writer: edits a BCD HH:MM working copy with push buttons and
// commits it to the alarm register that the alarm checker reads.
//
// Inputs push_* and SPDT_set are debounced levels. Each is registered once;
// a press event is a 0->1 transition of that registered value.
module alarm_time_setter #(
    parameter int          REPEAT_DELAY  = 50_000_000,
    parameter int          REPEAT_PERIOD = 10_000_000,
    parameter logic [15:0] ALARM_INIT    = 16'h0700
) (
    input  logic        clk,
    input  logic        resetn,      // active-high despite the name
    input  logic        SPDT_set,
    input  logic        push_l,
    input  logic        push_r,
    input  logic        push_u,
    input  logic        push_d,
    input  logic        push_c,
    output logic [15:0] alarm,
    output logic [15:0] disp_time,
    output logic        field_sel,
    output logic        editing,
    output logic        set_done
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(RPT_MAX + 1);
    localparam logic [CW-1:0] DELAY_C  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PERIOD_C = CW'(REPEAT_PERIOD);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    // Button vector bit positions
    localparam int BL = 0;
    localparam int BR = 1;
    localparam int BU = 2;
    localparam int BD = 3;
    localparam int BC = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EDIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   alarm_q, alarm_d;
    logic [15:0]   work_q, work_d;
    logic          field_q, field_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rpt_q, rpt_d;      // 1 once the first REPEAT_DELAY has elapsed
    logic [4:0]    btn_q, btn_prev_q;
    logic          spdt_q, spdt_prev_q;

    logic [4:0]    ev;
    logic          spdt_rise;
    logic          one_held;
    logic          do_step;
    logic          step_up;

    // Step one BCD field by +/-1 with wrap at 0 and top (23 or 59).
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                            input logic [7:0] top);
        logic [7:0] r;
        if (up) begin
            if (v == top)               r = 8'h00;
            else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
            else                        r = {v[7:4], v[3:0] + 4'd1};
        end else begin
            if (v == 8'h00)             r = top;
            else if (v[3:0] == 4'd0)    r = {v[7:4] - 4'd1, 4'd9};
            else                        r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    assign ev        = btn_q & ~btn_prev_q;
    assign spdt_rise = spdt_q & ~spdt_prev_q;
    assign one_held  = btn_q[BU] ^ btn_q[BD];

    // Input registers and their edge history
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            btn_q       <= '0;
            btn_prev_q  <= '0;
            spdt_q      <= 1'b0;
            spdt_prev_q <= 1'b0;
        end else begin
            btn_q       <= {push_c, push_d, push_u, push_r, push_l};
            btn_prev_q  <= btn_q;
            spdt_q      <= SPDT_set;
            spdt_prev_q <= spdt_q;
        end
    end

    // FSM and datapath state register
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= S_IDLE;
            alarm_q <= ALARM_INIT;
            work_q  <= ALARM_INIT;
            field_q <= 1'b0;
            cnt_q   <= '0;
            rpt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alarm_q <= alarm_d;
            work_q  <= work_d;
            field_q <= field_d;
            cnt_q   <= cnt_d;
            rpt_q   <= rpt_d;
        end
    end

    // Next-state: mode transitions, field edits and auto-repeat timing.
    // cnt_q == 0 means no repeat is armed; a press edge arms it at 1.
    always_comb begin
        state_d = state_q;
        alarm_d = alarm_q;
        work_d  = work_q;
        field_d = field_q;
        cnt_d   = cnt_q;
        rpt_d   = rpt_q;
        do_step = 1'b0;
        step_up = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                rpt_d = 1'b0;
                if (spdt_rise) begin
                    state_d = S_EDIT;
                    work_d  = alarm_q;
                    field_d = 1'b0;
                end
            end
            S_EDIT: begin
                if (!spdt_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    rpt_d   = 1'b0;
                end else if (ev[BC]) begin
                    state_d = S_COMMIT;
                    cnt_d   = '0;
                    rpt_d   = 1'b0;
                end else if (ev[BU] ^ ev[BD]) begin
                    do_step = 1'b1;
                    step_up = ev[BU];
                    cnt_d   = one_held ? ONE_C : '0;
                    rpt_d   = 1'b0;
                end else if (ev[BL] ^ ev[BR]) begin
                    field_d = ev[BR];
                    cnt_d   = '0;
                    rpt_d   = 1'b0;
                end else if ((cnt_q != '0) && one_held) begin
                    if (cnt_q == (rpt_q ? PERIOD_C : DELAY_C)) begin
                        do_step = 1'b1;
                        step_up = btn_q[BU];
                        cnt_d   = ONE_C;
                        rpt_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end else begin
                    cnt_d = '0;
                    rpt_d = 1'b0;
                end
            end
            S_COMMIT: begin
                alarm_d = work_q;
                cnt_d   = '0;
                rpt_d   = 1'b0;
                state_d = spdt_q ? S_EDIT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                rpt_d   = 1'b0;
            end
        endcase

        if (do_step) begin
            if (field_q) work_d[7:0]  = bcd_step(work_q[7:0], step_up, 8'h59);
            else         work_d[15:8] = bcd_step(work_q[15:8], step_up, 8'h23);
        end
    end

    // COMMIT counts as part of an edit session, so editing stays high across it.
    assign alarm     = alarm_q;
    assign disp_time = (state_q == S_IDLE) ? alarm_q : work_q;
    assign field_sel = field_q;
    assign editing   = (state_q != S_IDLE);
    assign set_done  = (state_q == S_COMMIT);

endmodule
